comp_sched256: RTL and testbench

COMP_SCHED256 -- requirements
Module: comp_sched256

---
 rtl/comp_sched256.sv | 138 +++++++++++++
 tb/tb_comp_sched256.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_sched256.sv
// Two-requester popcount scheduler: locks a packet to one requester, streams
// its columns through a shared compressor and accumulates per-packet results.
module comp_sched256 #(
    parameter int COMP_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [255:0] req0_data,
    input  logic         req0_last,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [255:0] req1_data,
    input  logic         req1_last,
    output logic         req1_ready,
    output logic [255:0] comp_in,
    input  logic [8:0]   comp_out,
    output logic         res_valid,
    output logic         res_id,
    output logic [16:0]  res_sum,
    output logic [8:0]   res_beats,
    output logic         res_trunc
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    typedef struct packed {
        logic       valid;
        logic       first;
        logic       fin;
        logic       trunc;
        logic       id;
        logic [8:0] beat;
    } tag_t;

    state_t      state_q;
    state_t      state_d;
    logic        last_gnt_q;
    logic [8:0]  beat_q;
    logic        gnt_id;
    logic        accept;
    logic        beat_last;
    logic        is_first;
    logic        fin;
    logic [8:0]  beat_num;
    tag_t        new_tag;
    tag_t        out_tag;
    tag_t        tag_q [COMP_LAT];
    logic [16:0] acc_q;
    logic [16:0] acc_d;

    // last_gnt_q records who won the most recent IDLE grant; the other wins ties
    always_comb begin
        state_d    = state_q;
        gnt_id     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_valid && (!req1_valid || last_gnt_q)) begin
                    req0_ready = 1'b1;
                end else if (req1_valid) begin
                    req1_ready = 1'b1;
                    gnt_id     = 1'b1;
                end
            end
            LOCK0: req0_ready = 1'b1;
            LOCK1: begin
                req1_ready = 1'b1;
                gnt_id     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
        accept    = (req0_ready && req0_valid) || (req1_ready && req1_valid);
        beat_last = gnt_id ? req1_last : req0_last;
        is_first  = (state_q == IDLE);
        beat_num  = is_first ? 9'd1 : beat_q + 9'd1;
        fin       = beat_last || (beat_num == 9'd256);
        comp_in   = '0;
        new_tag   = '0;
        if (accept) begin
            comp_in = gnt_id ? req1_data : req0_data;
            new_tag = '{valid: 1'b1, first: is_first, fin: fin,
                        trunc: fin && !beat_last, id: gnt_id,
                        beat: beat_num};
            state_d = fin ? IDLE : (gnt_id ? LOCK1 : LOCK0);
        end
    end

    assign out_tag = tag_q[COMP_LAT-1];
    assign acc_d   = out_tag.first ? {8'd0, comp_out}
                                   : acc_q + {8'd0, comp_out};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            beat_q     <= '0;
            acc_q      <= '0;
            res_valid  <= 1'b0;
            res_id     <= 1'b0;
            res_sum    <= '0;
            res_beats  <= '0;
            res_trunc  <= 1'b0;
            for (int i = 0; i < COMP_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                beat_q <= beat_num;
                if (is_first) begin
                    last_gnt_q <= gnt_id;
                end
            end
            // tags travel alongside the column inside the compressor
            tag_q[0] <= new_tag;
            for (int i = 1; i < COMP_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (out_tag.valid) begin
                acc_q <= acc_d;
            end
            res_valid <= out_tag.valid && out_tag.fin;
            if (out_tag.valid && out_tag.fin) begin
                res_id    <= out_tag.id;
                res_sum   <= acc_d;
                res_beats <= out_tag.beat;
                res_trunc <= out_tag.trunc;
            end
        end
    end

endmodule

// File: tb/tb_comp_sched256.sv
// Directed bench: two schedulers (COMP_LAT 1 and 3) share stimulus, each
// backed by its own popcount pipeline, results checked against hand values.
module tb_comp_sched256;

    typedef struct {
        logic        id;
        logic [16:0] sum;
        logic [8:0]  beats;
        logic        trunc;
        int          cyc;
    } res_t;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic [255:0] req0_data;
    logic         req0_last;
    logic         req1_valid;
    logic [255:0] req1_data;
    logic         req1_last;

    logic         rdy0_1, rdy1_1, rdy0_3, rdy1_3;
    logic [255:0] ci1, ci3;
    logic [8:0]   co1, co3;
    logic         r1_valid, r1_id, r1_trunc;
    logic [16:0]  r1_sum;
    logic [8:0]   r1_beats;
    logic         r3_valid, r3_id, r3_trunc;
    logic [16:0]  r3_sum;
    logic [8:0]   r3_beats;

    logic [8:0]   p1 [1];
    logic [8:0]   p3 [3];

    int   ncmp = 0;
    int   nerr = 0;
    int   cyc  = 0;
    res_t q1[$];
    res_t q3[$];
    res_t exp_q[$];

    comp_sched256 #(.COMP_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req0_last(req0_last), .req0_ready(rdy0_1),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .req1_last(req1_last), .req1_ready(rdy1_1),
        .comp_in(ci1), .comp_out(co1),
        .res_valid(r1_valid), .res_id(r1_id), .res_sum(r1_sum),
        .res_beats(r1_beats), .res_trunc(r1_trunc)
    );

    comp_sched256 #(.COMP_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req0_last(req0_last), .req0_ready(rdy0_3),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .req1_last(req1_last), .req1_ready(rdy1_3),
        .comp_in(ci3), .comp_out(co3),
        .res_valid(r3_valid), .res_id(r3_id), .res_sum(r3_sum),
        .res_beats(r3_beats), .res_trunc(r3_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        p1[0] <= 9'($countones(ci1));
        p3[0] <= 9'($countones(ci3));
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign co1 = p1[0];
    assign co3 = p3[2];

    always @(negedge clk) begin
        if (r1_valid === 1'b1)
            q1.push_back('{id: r1_id, sum: r1_sum, beats: r1_beats,
                           trunc: r1_trunc, cyc: cyc});
        if (r3_valid === 1'b1)
            q3.push_back('{id: r3_id, sum: r3_sum, beats: r3_beats,
                           trunc: r3_trunc, cyc: cyc});
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v0, input logic [255:0] d0,
                       input logic l0, input logic v1,
                       input logic [255:0] d1, input logic l1);
        req0_valid = v0;
        req0_data  = d0;
        req0_last  = l0;
        req1_valid = v1;
        req1_data  = d1;
        req1_last  = l1;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_rdy(input string tag, input logic e0, input logic e1);
        chk({tag, "_rdy0_l1"}, 256'(rdy0_1), 256'(e0));
        chk({tag, "_rdy1_l1"}, 256'(rdy1_1), 256'(e1));
        chk({tag, "_rdy0_l3"}, 256'(rdy0_3), 256'(e0));
        chk({tag, "_rdy1_l3"}, 256'(rdy1_3), 256'(e1));
    endtask

    task automatic expect_res(input logic id, input logic [16:0] sum,
                              input logic [8:0] beats, input logic trunc);
        exp_q.push_back('{id: id, sum: sum, beats: beats,
                          trunc: trunc, cyc: cyc});
    endtask

    task automatic check_res(input string p, input res_t r, input res_t e,
                             input int lat);
        chk({p, "_id"}, 256'(r.id), 256'(e.id));
        chk({p, "_sum"}, 256'(r.sum), 256'(e.sum));
        chk({p, "_beats"}, 256'(r.beats), 256'(e.beats));
        chk({p, "_trunc"}, 256'(r.trunc), 256'(e.trunc));
        chk({p, "_lat"}, 256'(r.cyc - e.cyc), 256'(lat));
    endtask

    task automatic wait_results(input string tag);
        int n;
        repeat (8) @(negedge clk);
        n = exp_q.size();
        chk({tag, "_nres_l1"}, 256'(q1.size()), 256'(n));
        chk({tag, "_nres_l3"}, 256'(q3.size()), 256'(n));
        for (int i = 0; i < n; i++) begin
            if (i < q1.size()) check_res({tag, "_l1"}, q1[i], exp_q[i], 1);
            if (i < q3.size()) check_res({tag, "_l3"}, q3[i], exp_q[i], 3);
        end
        q1.delete();
        q3.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        drv(1'b1, '1, 1'b1, 1'b1, '1, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk_rdy("rst", 1'b0, 1'b0);
        chk("rst_ci_l1", ci1, 256'd0);
        chk("rst_ci_l3", ci3, 256'd0);
        chk("rst_valid_l1", 256'(r1_valid), 256'd0);
        chk("rst_sum_l1", 256'(r1_sum), 256'd0);
        chk("rst_beats_l3", 256'(r3_beats), 256'd0);
        chk("rst_id_l3", 256'(r3_id), 256'd0);
        chk("rst_trunc_l1", 256'(r1_trunc), 256'd0);

        // single all-ones beat in the first cycle after reset release
        rst = 1'b0;
        drv(1'b1, '1, 1'b1, 1'b0, '0, 1'b0);
        chk_rdy("s1", 1'b1, 1'b0);
        chk("s1_ci", ci1, {256{1'b1}});
        edge_step();
        expect_res(1'b0, 17'd256, 9'd1, 1'b0);
        drv(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        wait_results("s1");
        chk("s1_hold_valid", 256'(r1_valid), 256'd0);
        chk("s1_hold_sum_l1", 256'(r1_sum), 256'd256);
        chk("s1_hold_sum_l3", 256'(r3_sum), 256'd256);

        // tie from reset alternates grants 0,1,0,1,0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drv(1'b1, 256'hF, 1'b1, 1'b1, 256'hFF, 1'b1);
            chk_rdy("s2", k % 2 == 0, k % 2 == 1);
            chk("s2_ci", ci1, (k % 2 == 0) ? 256'hF : 256'hFF);
            edge_step();
            expect_res(k % 2 == 1, (k % 2 == 1) ? 17'd8 : 17'd4,
                       9'd1, 1'b0);
        end
        drv(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        wait_results("s2");

        // req1 3-beat packet with a stall, req0 waiting throughout
        drv(1'b1, 256'h3, 1'b1, 1'b1, 256'h1F, 1'b0);
        chk_rdy("s3a", 1'b0, 1'b1);
        chk("s3a_ci", ci3, 256'h1F);
        edge_step();
        drv(1'b1, 256'h3, 1'b1, 1'b1, 256'h0, 1'b0);
        chk_rdy("s3b", 1'b0, 1'b1);
        edge_step();
        drv(1'b1, 256'h3, 1'b1, 1'b0, 256'h1FF, 1'b1);
        chk_rdy("s3c", 1'b0, 1'b1);
        chk("s3c_ci", ci1, 256'd0);
        edge_step();
        drv(1'b1, 256'h3, 1'b1, 1'b1, 256'h1FF, 1'b1);
        chk_rdy("s3d", 1'b0, 1'b1);
        chk("s3d_ci", ci1, 256'h1FF);
        edge_step();
        expect_res(1'b1, 17'd14, 9'd3, 1'b0);
        drv(1'b1, 256'h3, 1'b1, 1'b0, '0, 1'b0);
        chk_rdy("s3e", 1'b1, 1'b0);
        chk("s3e_ci", ci1, 256'h3);
        edge_step();
        expect_res(1'b0, 17'd2, 9'd1, 1'b0);
        drv(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        wait_results("s3");

        // 300 beats: truncation at 256, then a 44-beat packet
        for (int i = 1; i <= 300; i++) begin
            drv(1'b1, 256'h1, i == 300, 1'b0, '0, 1'b0);
            chk_rdy("s4", 1'b1, 1'b0);
            edge_step();
            if (i == 256) expect_res(1'b0, 17'd256, 9'd256, 1'b1);
            if (i == 300) expect_res(1'b0, 17'd44, 9'd44, 1'b0);
        end
        drv(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        wait_results("s4");

        // reset mid-packet discards it; a fresh packet follows
        drv(1'b1, 256'hF, 1'b0, 1'b0, '0, 1'b0);
        edge_step();
        drv(1'b1, 256'hF, 1'b0, 1'b0, '0, 1'b0);
        edge_step();
        rst = 1'b1;
        drv(1'b1, 256'hF, 1'b0, 1'b0, '0, 1'b0);
        chk_rdy("s5_rst", 1'b0, 1'b0);
        chk("s5_rst_ci", ci3, 256'd0);
        @(negedge clk);
        #1;
        chk("s5_rst_sum_l1", 256'(r1_sum), 256'd0);
        chk("s5_rst_sum_l3", 256'(r3_sum), 256'd0);
        rst = 1'b0;
        drv(1'b1, 256'h7F, 1'b1, 1'b0, '0, 1'b0);
        chk_rdy("s5", 1'b1, 1'b0);
        edge_step();
        expect_res(1'b0, 17'd7, 9'd1, 1'b0);
        drv(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        wait_results("s5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
